// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status bit layout
// and the exception-source selector used by the priority logic.
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT    = 5'd0;
    localparam logic [4:0] EXC_SYS    = 5'd8;
    localparam logic [4:0] EXC_UNIMPL = 5'd10;
    localparam logic [4:0] EXC_OV     = 5'd12;

    localparam int ST_INT    = 0;
    localparam int ST_SYS    = 1;
    localparam int ST_UNIMPL = 2;
    localparam int ST_OV     = 3;

    localparam logic [31:0] EXC_BASE_DEFAULT = 32'h0000_0008;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_ERET,
        SRC_UNIMPL,
        SRC_SYS,
        SRC_OV,
        SRC_INT
    } exc_src_e;

    function automatic logic [4:0] exc_code(input exc_src_e src);
        case (src)
            SRC_UNIMPL: exc_code = EXC_UNIMPL;
            SRC_SYS:    exc_code = EXC_SYS;
            SRC_OV:     exc_code = EXC_OV;
            default:    exc_code = EXC_INT;
        endcase
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_intr_sync.sv
// External interrupt synchronizer chain, rising-edge detector and pending latch.
// A new edge in the same cycle as clr keeps the interrupt pending.
module intr_sync
    import cp0_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clrn,
    input  logic intr,
    input  logic clr,
    output logic pend
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   prev_reg;
    logic                   pend_reg;
    logic                   pend_next;
    logic                   rise;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = intr;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign rise      = sync_reg[SYNC_STAGES-1] & ~prev_reg;
    assign pend_next = rise | (pend_reg & ~clr);
    assign pend      = pend_reg;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            pend_reg <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            prev_reg <= sync_reg[SYNC_STAGES-1];
            pend_reg <= pend_next;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status/Cause/EPC, prioritised exception
// selection, same-cycle redirect and write-back cancel, eret and mtc0/mfc0.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_BASE    = EXC_BASE_DEFAULT,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [31:0] pc_cur,
    input  logic [31:0] pc_nxt,
    input  logic        ov,
    input  logic        ov_chk,
    input  logic        sys,
    input  logic        unimpl,
    input  logic        eret,
    input  logic        mtc0,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    input  logic        intr,
    output logic [31:0] rdata,
    output logic        exc,
    output logic [31:0] exc_pc,
    output logic        inta,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc
);

    logic [7:0]  status_reg, status_next;
    logic [4:0]  cause_reg,  cause_next;
    logic [31:0] epc_reg,    epc_next;
    logic        inta_reg,   inta_next;
    logic        pend;
    logic        int_taken;
    logic        active;
    exc_src_e    src_sel;

    intr_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_intr_sync (
        .clk  (clk),
        .clrn (clrn),
        .intr (intr),
        .clr  (int_taken),
        .pend (pend)
    );

    // Fixed priority: eret > unimpl > sys > ov > int.
    always_comb begin
        src_sel = SRC_NONE;
        if (eret)
            src_sel = SRC_ERET;
        else if (unimpl && status_reg[ST_UNIMPL])
            src_sel = SRC_UNIMPL;
        else if (sys && status_reg[ST_SYS])
            src_sel = SRC_SYS;
        else if (ov && ov_chk && status_reg[ST_OV])
            src_sel = SRC_OV;
        else if (pend && status_reg[ST_INT])
            src_sel = SRC_INT;
    end

    assign active    = clrn & ~stall;
    assign exc       = active & (src_sel != SRC_NONE);
    assign int_taken = exc & (src_sel == SRC_INT);
    assign exc_pc    = (clrn && src_sel == SRC_ERET) ? epc_reg : EXC_BASE;

    always_comb begin
        status_next = status_reg;
        cause_next  = cause_reg;
        epc_next    = epc_reg;
        inta_next   = 1'b0;
        if (exc) begin
            if (src_sel == SRC_ERET) begin
                status_next = {4'b0, status_reg[7:4]};
            end else begin
                status_next = {status_reg[3:0], 4'b0};
                cause_next  = exc_code(src_sel);
                epc_next    = int_taken ? pc_nxt : pc_cur;
                inta_next   = int_taken;
            end
        end else if (active && mtc0) begin
            case (cp0_addr)
                CP0_STATUS: status_next = wdata[7:0];
                CP0_CAUSE:  cause_next  = wdata[6:2];
                CP0_EPC:    epc_next    = wdata;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            status_reg <= '0;
            cause_reg  <= '0;
            epc_reg    <= '0;
            inta_reg   <= 1'b0;
        end else begin
            status_reg <= status_next;
            cause_reg  <= cause_next;
            epc_reg    <= epc_next;
            inta_reg   <= inta_next;
        end
    end

    assign status = {24'b0, status_reg};
    assign cause  = {25'b0, cause_reg, 2'b0};
    assign epc    = epc_reg;
    assign inta   = inta_reg;

    always_comb begin
        case (cp0_addr)
            CP0_STATUS: rdata = status;
            CP0_CAUSE:  rdata = cause;
            CP0_EPC:    rdata = epc;
            default:    rdata = 32'b0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: directed scenarios followed by random
// traffic, both checked against a behavioural CP0 model.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] EXC_BASE = 32'h0000_0008;
    localparam int          SYNC     = 2;

    logic        clk = 1'b0;
    logic        clrn, stall, ov, ov_chk, sys, unimpl, eret, mtc0, intr;
    logic [31:0] pc_cur, pc_nxt, wdata;
    logic [4:0]  cp0_addr;
    logic [31:0] rdata, exc_pc, status, cause, epc;
    logic        exc, inta;

    cp0_exc_ctrl #(
        .EXC_BASE    (EXC_BASE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .stall    (stall),
        .pc_cur   (pc_cur),
        .pc_nxt   (pc_nxt),
        .ov       (ov),
        .ov_chk   (ov_chk),
        .sys      (sys),
        .unimpl   (unimpl),
        .eret     (eret),
        .mtc0     (mtc0),
        .cp0_addr (cp0_addr),
        .wdata    (wdata),
        .intr     (intr),
        .rdata    (rdata),
        .exc      (exc),
        .exc_pc   (exc_pc),
        .inta     (inta),
        .status   (status),
        .cause    (cause),
        .epc      (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clrn, stall, ov, ov_chk, sys, unimpl, eret, mtc0, intr;
        logic [4:0]  addr;
        logic [31:0] pc_cur, pc_nxt, wdata;
    } stim_t;

    typedef struct {
        logic        exc;
        logic        chk_pc;
        logic [31:0] exc_pc, rdata, status, cause, epc;
        logic        inta;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // Reference model state: architectural view of CP0 plus intr history.
    logic [7:0]  m_status = '0;
    logic [31:0] m_cause  = '0;
    logic [31:0] m_epc    = '0;
    logic        m_pend   = 1'b0;
    logic        m_inta   = 1'b0;
    logic        hist [0:SYNC];   // hist[k] = intr sampled k edges ago
    logic        intr_lvl = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s txn=%0d got=%h expected=%h", nm, txn, act, expv);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{clrn: 1'b1, stall: 1'b0, ov: 1'b0, ov_chk: 1'b0, sys: 1'b0,
              unimpl: 1'b0, eret: 1'b0, mtc0: 1'b0, intr: intr_lvl,
              addr: 5'd0, pc_cur: 32'h100, pc_nxt: 32'h104, wdata: 32'h0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t        e;
        int          win;   // 0 none, 1 eret, 2 unimpl, 3 sys, 4 ov, 5 int
        logic        rise, pend_new;
        logic [31:0] reg_view [3];
        @(posedge clk);
        #1;
        clrn = s.clrn; stall = s.stall; ov = s.ov; ov_chk = s.ov_chk;
        sys = s.sys; unimpl = s.unimpl; eret = s.eret; mtc0 = s.mtc0;
        intr = s.intr; cp0_addr = s.addr; pc_cur = s.pc_cur;
        pc_nxt = s.pc_nxt; wdata = s.wdata;

        win = 0;
        if (s.eret)                              win = 1;
        else if (s.unimpl && m_status[2])        win = 2;
        else if (s.sys && m_status[1])           win = 3;
        else if (s.ov && s.ov_chk && m_status[3]) win = 4;
        else if (m_pend && m_status[0])          win = 5;

        reg_view[0] = {24'b0, m_status};
        reg_view[1] = m_cause;
        reg_view[2] = m_epc;
        e.exc    = s.clrn && !s.stall && win != 0;
        e.chk_pc = e.exc || !s.clrn;
        e.exc_pc = (s.clrn && win == 1) ? m_epc : EXC_BASE;
        e.rdata  = (s.addr >= 12 && s.addr <= 14) ? reg_view[s.addr - 12] : 32'h0;
        e.status = reg_view[0];
        e.cause  = m_cause;
        e.epc    = m_epc;
        e.inta   = m_inta;
        exp_q.push_back(e);

        if (!s.clrn) begin
            m_status = '0; m_cause = '0; m_epc = '0; m_pend = 0; m_inta = 0;
            for (int k = 0; k <= SYNC; k++) hist[k] = 1'b0;
        end else begin
            rise     = hist[SYNC-1] && !hist[SYNC];
            pend_new = rise || (m_pend && !(e.exc && win == 5));
            m_inta   = e.exc && win == 5;
            if (e.exc && win == 1) begin
                m_status = m_status >> 4;
            end else if (e.exc) begin
                m_status = m_status << 4;
                m_epc    = (win == 5) ? s.pc_nxt : s.pc_cur;
                case (win)
                    2:       m_cause = 10 * 4;
                    3:       m_cause = 8 * 4;
                    4:       m_cause = 12 * 4;
                    default: m_cause = 0;
                endcase
            end else if (!s.stall && s.mtc0) begin
                if (s.addr == 12) m_status = s.wdata[7:0];
                if (s.addr == 13) m_cause  = s.wdata & 32'h7C;
                if (s.addr == 14) m_epc    = s.wdata;
            end
            for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = s.intr;
            m_pend  = pend_new;
        end
    endtask

    // Monitor: every cycle the DUT presents a full response; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d exc=%0b exc_pc=%h status=%h cause=%h epc=%h inta=%0b",
                         txn, exc, exc_pc, status, cause, epc, inta);
                chk("exc", {31'b0, exc}, {31'b0, e.exc});
                if (e.chk_pc) chk("exc_pc", exc_pc, e.exc_pc);
                chk("rdata", rdata, e.rdata);
                chk("status", status, e.status);
                chk("cause", cause, e.cause);
                chk("epc", epc, e.epc);
                chk("inta", {31'b0, inta}, {31'b0, e.inta});
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cnt;
        for (int k = 0; k <= SYNC; k++) hist[k] = 1'b0;
        clrn = 0; stall = 0; ov = 0; ov_chk = 0; sys = 0; unimpl = 0; eret = 0;
        mtc0 = 0; intr = 0; cp0_addr = 0; pc_cur = 0; pc_nxt = 0; wdata = 0;

        s = idle(); s.clrn = 0;
        repeat (3) apply(s);
        // Overflow trap and eret return.
        s = idle(); s.mtc0 = 1; s.addr = 12; s.wdata = 32'h8; apply(s);
        s = idle(); s.ov = 1; s.ov_chk = 1; s.pc_cur = 32'h40; s.pc_nxt = 32'h44; s.addr = 13; apply(s);
        s = idle(); s.addr = 14; apply(s);
        s = idle(); s.eret = 1; s.addr = 12; apply(s);
        s = idle(); apply(s);
        // Interrupt taken after the synchronizer latency.
        s = idle(); s.mtc0 = 1; s.addr = 12; s.wdata = 32'h1; apply(s);
        intr_lvl = 1;
        repeat (5) begin s = idle(); apply(s); end
        intr_lvl = 0;
        repeat (2) begin s = idle(); apply(s); end
        // Syscall beats a pending interrupt; interrupt follows the eret.
        s = idle(); s.mtc0 = 1; s.addr = 12; s.wdata = 32'hE; apply(s);
        intr_lvl = 1;
        repeat (4) begin s = idle(); apply(s); end
        s = idle(); s.mtc0 = 1; s.addr = 12; s.wdata = 32'hF; apply(s);
        s = idle(); s.sys = 1; s.pc_cur = 32'h200; apply(s);
        s = idle(); s.eret = 1; apply(s);
        s = idle(); apply(s);
        s = idle(); apply(s);
        intr_lvl = 0;
        // Suppressed traps: masked overflow, unchecked overflow, stall.
        s = idle(); s.ov = 1; s.ov_chk = 1; apply(s);
        s = idle(); s.mtc0 = 1; s.addr = 12; s.wdata = 32'hF; apply(s);
        s = idle(); s.ov = 1; s.ov_chk = 0; apply(s);
        s = idle(); s.stall = 1; s.unimpl = 1; s.mtc0 = 1; s.addr = 14; s.wdata = 32'h55; apply(s);
        // Reset in the middle of a handler.
        s = idle(); s.unimpl = 1; s.pc_cur = 32'h300; apply(s);
        s = idle(); s.clrn = 0; apply(s);
        s = idle(); s.addr = 12; apply(s);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(11) == 0) intr_lvl = ~intr_lvl;
            s = idle();
            s.clrn   = ($urandom_range(99) != 0);
            s.stall  = ($urandom_range(7) == 0);
            s.ov     = $urandom_range(1);
            s.ov_chk = $urandom_range(1);
            s.sys    = ($urandom_range(7) == 0);
            s.unimpl = ($urandom_range(9) == 0);
            s.eret   = ($urandom_range(9) == 0);
            s.mtc0   = ($urandom_range(3) == 0);
            s.addr   = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'(12 + $urandom_range(2));
            s.wdata  = $urandom;
            s.pc_cur = {$urandom_range(32'h3FFF), 2'b00};
            s.pc_nxt = ($urandom_range(3) == 0) ? {$urandom_range(32'h3FFF), 2'b00} : s.pc_cur + 4;
            apply(s);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
